// File: rtl/sal_req_arb.sv
// sal_req_arb: round-robin command arbiter onto one DRAM controller port,
// with in-order write-data steering and read-data demux by id index.
module sal_req_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 4,
  parameter int RA_W     = 14,
  parameter int CA_W     = 10,
  parameter int WQ_DEPTH = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int REQ_P   = ID_W + RA_W + CA_W + 5,
  localparam int MREQ_P  = REQ_P + IDX_W,
  localparam int W_P     = 145,
  localparam int SR_P    = ID_W + 131,
  localparam int MR_P    = SR_P + IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       s_req_valid,
  output logic [NUM_REQ-1:0]       s_req_ready,
  input  logic [NUM_REQ*REQ_P-1:0] s_req_payload,
  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [MREQ_P-1:0]        m_req_payload,
  input  logic [NUM_REQ-1:0]       s_wvalid,
  output logic [NUM_REQ-1:0]       s_wready,
  input  logic [NUM_REQ*W_P-1:0]   s_wpayload,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic [W_P-1:0]           m_wpayload,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [MR_P-1:0]          m_rpayload,
  output logic [NUM_REQ-1:0]       s_rvalid,
  input  logic [NUM_REQ-1:0]       s_rready,
  output logic [SR_P-1:0]          s_rpayload
);

  localparam int PW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

  logic [REQ_P-1:0]   req_a [NUM_REQ];
  logic [W_P-1:0]     w_a   [NUM_REQ];
  logic [NUM_REQ-1:0] elig;

  logic               slot_v_q, slot_v_d;
  logic [MREQ_P-1:0]  slot_q, slot_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win;
  logic               win_v;
  logic               load_ok;
  logic               acc;

  logic [IDX_W-1:0]   wq_q [WQ_DEPTH];
  logic [PW-1:0]      wp_q, wp_d;
  logic [PW-1:0]      rp_q, rp_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic               wq_full;
  logic               wq_empty;
  logic               push;
  logic               pop;
  logic [IDX_W-1:0]   head;

  logic [IDX_W-1:0]   rk;
  logic               rk_ok;

  assign wq_full  = (cnt_q == (PW+1)'(WQ_DEPTH));
  assign wq_empty = (cnt_q == '0);
  assign head     = wq_q[rp_q];

  // Writes are held off while the order queue is full so no beat loses its owner.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_a[g] = s_req_payload[g*REQ_P +: REQ_P];
    assign w_a[g]   = s_wpayload[g*W_P +: W_P];
    assign elig[g]  = s_req_valid[g] & (~req_a[g][4] | ~wq_full);
  end

  always_comb begin
    int c;
    c     = 0;
    win_v = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = int'((32'(last_q) + 32'(k)) % 32'(NUM_REQ));
      if (!win_v && elig[c]) begin
        win_v = 1'b1;
        win   = IDX_W'(c);
      end
    end
  end

  assign load_ok = ~slot_v_q | m_req_ready;
  assign acc     = ~rst & load_ok & win_v;

  always_comb begin
    s_req_ready = '0;
    if (acc) s_req_ready[win] = 1'b1;
  end

  always_comb begin
    slot_v_d = slot_v_q;
    slot_d   = slot_q;
    last_d   = last_q;
    if (acc) begin
      slot_v_d = 1'b1;
      slot_d   = {win, req_a[win]};
      last_d   = win;
    end else if (m_req_ready) begin
      slot_v_d = 1'b0;
    end
  end

  assign m_req_valid   = slot_v_q;
  assign m_req_payload = slot_q;

  assign push = acc & req_a[win][4];
  assign pop  = m_wvalid & m_wready & m_wpayload[0];

  always_comb begin
    s_wready   = '0;
    m_wvalid   = 1'b0;
    m_wpayload = '0;
    if (!wq_empty) begin
      m_wvalid       = s_wvalid[head];
      m_wpayload     = w_a[head];
      s_wready[head] = m_wready;
    end
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    if (push) wp_d = (wp_q == PW'(WQ_DEPTH-1)) ? '0 : wp_q + 1'b1;
    if (pop)  rp_d = (rp_q == PW'(WQ_DEPTH-1)) ? '0 : rp_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) wq_q[wp_q] <= win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v_q <= 1'b0;
      slot_q   <= '0;
      last_q   <= IDX_W'(NUM_REQ-1);
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      slot_q   <= slot_d;
      last_q   <= last_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
    end
  end

  // Beats carrying an index with no requester are sunk so the controller never stalls.
  assign rk    = m_rpayload[MR_P-1 -: IDX_W];
  assign rk_ok = (32'(rk) < 32'(NUM_REQ));

  assign s_rvalid   = rk_ok ? (NUM_REQ'(m_rvalid) << rk) : '0;
  assign m_rready   = rk_ok ? s_rready[rk] : 1'b1;
  assign s_rpayload = m_rpayload[SR_P-1:0];

endmodule

// File: doc/sal_req_arb.md
SAL_REQ_ARB -- requirements
Module: sal_req_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; IDX_W = clog2(NUM_REQ).
REQ-002 Parameter ID_W, default 4: requester-side transaction ID width.
REQ-003 Parameter RA_W, default 14: DRAM row address width.
REQ-004 Parameter CA_W, default 10: DRAM column address width.
REQ-005 Parameter WQ_DEPTH, default 4: write-order queue entries (power of 2).
REQ-006 Payload bundles: REQ_P = {id[ID_W], ra[RA_W], ca[CA_W], wr[1], len[4]}; W_P = {data[128], strb[16], last[1]}; R_P = {id, data[128], resp[2], last[1]}.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 s_req_valid  in  NUM_REQ  per-requester command valid.
REQ-010 s_req_ready  out  NUM_REQ  per-requester command accept.
REQ-011 s_req_payload  in  NUM_REQ*REQ_P  packed per-requester commands, requester 0 in LSBs.
REQ-012 m_req_valid  out  1  command to DRAM controller valid.
REQ-013 m_req_ready  in  1  DRAM controller accepts command.
REQ-014 m_req_payload  out  REQ_P with id widened to IDX_W+ID_W  granted command, id = {idx, id}.
REQ-015 s_wvalid / s_wready  in / out  NUM_REQ each  per-requester write-data handshake.
REQ-016 s_wpayload  in  NUM_REQ*W_P  packed per-requester write beats.
REQ-017 m_wvalid / m_wready  out / in  1 each  write-data handshake to controller.
REQ-018 m_wpayload  out  W_P  selected write beat.
REQ-019 m_rvalid / m_rready  in / out  1 each  read-data handshake from controller.
REQ-020 m_rpayload  in  R_P with id width IDX_W+ID_W  read beat from controller.
REQ-021 s_rvalid / s_rready  out / in  NUM_REQ each  per-requester read handshake.
REQ-022 s_rpayload  out  R_P with id width ID_W  read beat broadcast to all requesters, index bits stripped.

Function
REQ-023 Output slot: single registered entry; slot load allowed when slot empty or (m_req_valid & m_req_ready) in the same cycle.
REQ-024 Eligibility: requester i eligible when s_req_valid[i] and (wr=0 or write-order queue not full); full flag is current-cycle only, no same-cycle pop bypass.
REQ-025 Round-robin: search starts at last_grant+1, wraps modulo NUM_REQ; first eligible wins.
REQ-026 s_req_ready one-hot or zero: high only for winner, and only when slot load allowed.
REQ-027 On accept: slot loads payload with id = {winner idx, id}; last_grant = winner; m_req_valid high next cycle (latency 1).
REQ-028 m_req_payload and m_req_valid held stable while m_req_valid=1 and m_req_ready=0.
REQ-029 No eligible requester and slot draining: m_req_valid falls next cycle.
REQ-030 Write-order queue: accepted wr=1 command pushes winner idx; beats of that command pass from the next cycle.
REQ-031 W mux: queue non-empty -> m_wvalid = s_wvalid[head], m_wpayload = s_wpayload[head], s_wready[head] = m_wready; all other s_wready=0.
REQ-032 Queue empty: m_wvalid=0, all s_wready=0.
REQ-033 Pop head on beat with m_wvalid & m_wready & last; push and pop in same cycle are both allowed when not full.
REQ-034 R demux, combinational: k = m_rid[IDX_W+ID_W-1:ID_W]; s_rvalid = m_rvalid << k; m_rready = s_rready[k].
REQ-035 m_rid indices >= NUM_REQ: m_rready=1, beat discarded, all s_rvalid=0.

Reset
REQ-036 While rst=1 at a clock edge: slot empty; queue empty; last_grant = NUM_REQ-1 (requester 0 granted first).
REQ-037 Register-driven outputs after reset: m_req_valid=0, s_req_ready=0, m_wvalid=0, s_wready=0; mid-operation reset discards held command and queue contents.

Verification
REQ-038 All 4 requesters issue back-to-back reads, m_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; m_req id MSBs 0,1,2,3,0.
REQ-039 m_req_ready=0 for 5 cycles with slot full -> payload stable; all s_req_ready=0; first accept after ready returns = next RR winner.
REQ-040 Write len=1 from req2, then write from req1; req1 drives W first -> req1 stalled until req2's last beat accepted, then req1's 2 beats pass.
REQ-041 4 writes accepted, no W data -> 5th write not granted; concurrent read from req3 still granted.
REQ-042 m_rid = {2'd3, 4'h5}, m_rvalid=1 -> s_rvalid=4'b1000, s_rpayload id=4'h5, m_rready tracks s_rready[3].
REQ-043 rst pulsed with m_req_valid=1 and queue holding 2 entries -> next cycle m_req_valid=0, m_wvalid=0; first post-reset grant to req0.
